dual_port_ram_be: RTL and testbench

Parametrised simple dual-port RAM with one write port and one read port. It adds per-byte write enables, a selectable read latency of 1 or 2 cycles, a selectable read-during-write policy, and a valid strobe on read data. A built-in clear engine fills every word with a constant after reset and on request. It is the general-purpose on-chip buffer for line stores, FIFOs and lookup tables that need a known initial state.

---
 rtl/dual_port_ram_be.sv | 130 +++++++++++++
 tb/tb_dual_port_ram_be.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM with byte-lane write enables, 1- or 2-cycle read latency,
// selectable read-during-write policy and a self-clearing sweep after reset or on request.
module dual_port_ram_be #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    BYTE_WIDTH   = 8,
  parameter int                    READ_LATENCY = 1,
  parameter int                    RDW_MODE     = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
  input  logic [ADDR_WIDTH-1:0]            write_addr,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            read_addr,
  input  logic                             clear,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             data_valid,
  output logic                             busy
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NB-1:0]           wr_be;
  logic [DATA_WIDTH-1:0]   merged_word;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic                    rd_valid1_q, rd_valid1_d;
  logic [DATA_WIDTH-1:0]   rd_data1_q, rd_data1_d;
  logic                    rd_valid2_q, rd_valid2_d;
  logic [DATA_WIDTH-1:0]   rd_data2_q, rd_data2_d;

  // The sweep owns the write port while clearing; user accesses are only accepted in READY.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_en     = 1'b0;
    wr_addr   = write_addr;
    wr_data   = data_in;
    wr_be     = be;
    rd_en     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        wr_en     = 1'b1;
        wr_addr   = clr_cnt_q;
        wr_data   = CLEAR_VALUE;
        wr_be     = '1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_READY;
      end
      default: begin
        wr_en = we;
        rd_en = re;
        if (clear) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
    endcase
    if (rst) begin
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
  end

  always_comb begin
    merged_word = mem_q[wr_addr];
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Write-first mode forwards the merged word; otherwise the array read sees the pre-write value.
  always_comb begin
    rd_word = mem_q[read_addr];
    if (RDW_MODE == 1 && wr_en && (wr_addr == read_addr)) rd_word = merged_word;
  end

  // re is a one-cycle request with no back-pressure; data_valid pulses once per accepted read.
  always_comb begin
    rd_valid1_d = rd_en;
    rd_data1_d  = rd_en ? rd_word : rd_data1_q;
    rd_valid2_d = rd_valid1_q;
    rd_data2_d  = rd_valid1_q ? rd_data1_q : rd_data2_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= merged_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      rd_valid1_q <= 1'b0;
      rd_data1_q  <= '0;
      rd_valid2_q <= 1'b0;
      rd_data2_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rd_valid1_q <= rd_valid1_d;
      rd_data1_q  <= rd_data1_d;
      rd_valid2_q <= rd_valid2_d;
      rd_data2_q  <= rd_data2_d;
    end
  end

  assign data_out   = (READ_LATENCY == 2) ? rd_data2_q  : rd_data1_q;
  assign data_valid = (READ_LATENCY == 2) ? rd_valid2_q : rd_valid1_q;
  assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench for dual_port_ram_be: three instances share one stimulus stream
// (latency 1 old-data, latency 1 write-first, latency 2 old-data).
module tb_dual_port_ram_be;

  logic        clk;
  logic        rst;
  logic        we;
  logic [3:0]  be;
  logic [3:0]  write_addr;
  logic [31:0] data_in;
  logic        re;
  logic [3:0]  read_addr;
  logic        clear;

  logic [31:0] dout0, dout1, dout2;
  logic        dv0, dv1, dv2;
  logic        busy0, busy1, busy2;

  int checks   = 0;
  int failures = 0;
  int stray    = 0;
  logic [31:0] exp_q[$];

  dual_port_ram_be #(.READ_LATENCY(1), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .we(we), .be(be), .write_addr(write_addr), .data_in(data_in),
    .re(re), .read_addr(read_addr), .clear(clear),
    .data_out(dout0), .data_valid(dv0), .busy(busy0));

  dual_port_ram_be #(.READ_LATENCY(1), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .we(we), .be(be), .write_addr(write_addr), .data_in(data_in),
    .re(re), .read_addr(read_addr), .clear(clear),
    .data_out(dout1), .data_valid(dv1), .busy(busy1));

  dual_port_ram_be #(.READ_LATENCY(2), .RDW_MODE(0)) u_dut2 (
    .clk(clk), .rst(rst), .we(we), .be(be), .write_addr(write_addr), .data_in(data_in),
    .re(re), .read_addr(read_addr), .clear(clear),
    .data_out(dout2), .data_valid(dv2), .busy(busy2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; be = 4'h0; write_addr = 4'h0; data_in = 32'h0;
    re = 1'b0; read_addr = 4'h0; clear = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (dv0 || dv1 || dv2) stray++;
      if (!busy0) break;
    end
  endtask

  task automatic write_word(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; write_addr = a; data_in = d; be = b;
    tick();
    we = 1'b0; be = 4'h0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    re = 1'b1; read_addr = a;
    tick();
    re = 1'b0;
    check({tag, "_valid"}, 32'(dv0), 32'd1);
    check({tag, "_data"}, dout0, exp);
    check({tag, "_data_wf"}, dout1, exp);
  endtask

  initial begin
    int n;
    int vcount;
    logic [31:0] got;
    idle();
    rst = 1'b1;
    tick(); tick();
    check("rst_data_out", dout0, 32'h0);
    check("rst_data_valid", 32'(dv0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd1);
    check("rst_busy_lat2", 32'(busy2), 32'd1);
    rst = 1'b0;
    wait_ready(n);
    check("init_sweep_edges", n, 32'd16);

    // reset clear of a filled array
    for (int a = 0; a < 16; a++) write_word(4'(a), 32'hA5A5A5A5, 4'hF);
    read_check("fill_check", 4'd9, 32'hA5A5A5A5);
    rst = 1'b1; tick(); rst = 1'b0;
    stray = 0;
    wait_ready(n);
    check("reset_sweep_edges", n, 32'd16);
    check("reset_sweep_no_valid", stray, 32'd0);
    for (int a = 0; a < 16; a++) read_check($sformatf("cleared_%0d", a), 4'(a), 32'h0);

    // byte enables
    write_word(4'd3, 32'h11223344, 4'hF);
    write_word(4'd3, 32'hAABBCCDD, 4'b0101);
    read_check("byte_enable", 4'd3, 32'h11BB33DD);
    write_word(4'd3, 32'hFFFFFFFF, 4'b0000);
    read_check("be_zero_noop", 4'd3, 32'h11BB33DD);

    // read-during-write at address 7
    we = 1'b1; write_addr = 4'd7; data_in = 32'hDEADBEEF; be = 4'hF;
    re = 1'b1; read_addr = 4'd7;
    tick();
    idle();
    check("rdw_old_valid", 32'(dv0), 32'd1);
    check("rdw_old_data", dout0, 32'h0);
    check("rdw_new_valid", 32'(dv1), 32'd1);
    check("rdw_new_data", dout1, 32'hDEADBEEF);
    tick();
    check("rdw_lat2_valid", 32'(dv2), 32'd1);
    check("rdw_lat2_data", dout2, 32'h0);
    read_check("rdw_after", 4'd7, 32'hDEADBEEF);

    // latency 2 back-to-back reads via the expected queue
    write_word(4'd0, 32'd10, 4'hF);
    write_word(4'd1, 32'd11, 4'hF);
    write_word(4'd2, 32'd12, 4'hF);
    tick();
    exp_q.push_back(32'd10); exp_q.push_back(32'd11); exp_q.push_back(32'd12);
    vcount = 0;
    for (int t = 0; t < 6; t++) begin
      re = (t < 3); read_addr = 4'(t);
      tick();
      check($sformatf("lat2_valid_t%0d", t), 32'(dv2), 32'((t >= 1) && (t <= 3)));
      if (dv2) begin
        vcount++;
        if (exp_q.size() > 0) begin
          got = exp_q.pop_front();
          check($sformatf("lat2_data_t%0d", t), dout2, got);
        end else begin
          check("lat2_extra_valid", 32'd1, 32'd0);
        end
      end
    end
    idle();
    check("lat2_valid_count", vcount, 32'd3);
    check("lat2_queue_empty", exp_q.size(), 32'd0);
    check("lat2_hold", dout2, 32'd12);

    // clear with same-edge user access, then clear+write while busy
    clear = 1'b1; re = 1'b1; read_addr = 4'd3;
    we = 1'b1; write_addr = 4'd9; data_in = 32'h99999999; be = 4'hF;
    tick();
    idle();
    check("clear_busy_set", 32'(busy0), 32'd1);
    check("clear_edge_read_valid", 32'(dv0), 32'd1);
    check("clear_edge_read_data", dout0, 32'h11BB33DD);
    n = 1;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) begin
        clear = 1'b1; re = 1'b1; read_addr = 4'd5;
        we = 1'b1; write_addr = 4'd5; data_in = 32'hFFFFFFFF; be = 4'hF;
      end
      tick();
      if (i == 0) stray = 0;
      idle();
      if (dv0 || dv1) stray++;
      if (busy0) n++;
      else break;
    end
    check("clear_busy_cycles", n, 32'd16);
    check("busy_read_ignored", stray, 32'd0);
    read_check("busy_write_ignored", 4'd5, 32'h0);
    read_check("clear_edge_write_swept", 4'd9, 32'h0);
    read_check("clear_wiped", 4'd3, 32'h0);

    // reset in the middle of a sweep
    write_word(4'd12, 32'h12345678, 4'hF);
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (9) tick();
    rst = 1'b1; re = 1'b1; read_addr = 4'd12;
    tick();
    idle();
    check("midsweep_rst_busy", 32'(busy0), 32'd1);
    check("midsweep_rst_valid", 32'(dv0), 32'd0);
    rst = 1'b0;
    stray = 0;
    wait_ready(n);
    check("midsweep_restart_edges", n, 32'd16);
    check("midsweep_no_valid", stray, 32'd0);
    read_check("midsweep_word12", 4'd12, 32'h0);

    // reset flushes a read still in the latency-2 pipeline
    write_word(4'd6, 32'h600D600D, 4'hF);
    re = 1'b1; read_addr = 4'd6;
    tick();
    re = 1'b0;
    check("flush_lat1_data", dout0, 32'h600D600D);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("flush_lat2_valid", 32'(dv2), 32'd0);
    check("flush_lat2_data", dout2, 32'h0);
    check("flush_lat1_valid", 32'(dv0), 32'd0);
    stray = 0;
    wait_ready(n);
    check("flush_sweep_edges", n, 32'd16);
    check("flush_no_valid", stray, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
